multicycle_control: RTL and testbench

- Moore/Mealy control FSM for the multicycle 32-bit CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit selects of the downstream 4:1 32-bit datapath muxes (ALU B operand, PC source) plus all register/memory enables.
- Waits on a memory-ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_out_decode.sv | 78 +++++++
 rtl/multicycle_control.sv | 111 +++++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states, mux selects.
// States 11/12 are only reachable when MULTICYCLE_ADDI_EN is defined.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = STATE_W'(0),
        S_FETCH     = STATE_W'(1),
        S_DECODE    = STATE_W'(2),
        S_MEM_ADDR  = STATE_W'(3),
        S_MEM_READ  = STATE_W'(4),
        S_MEM_WB    = STATE_W'(5),
        S_MEM_WRITE = STATE_W'(6),
        S_EXECUTE   = STATE_W'(7),
        S_R_WB      = STATE_W'(8),
        S_BRANCH    = STATE_W'(9),
        S_JUMP      = STATE_W'(10),
        S_ADDI_EX   = STATE_W'(11),
        S_ADDI_WB   = STATE_W'(12)
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decoder: registered state (plus mem_ready for fetch) -> datapath controls.
// ADDI states decode only when MULTICYCLE_ADDI_EN is defined.
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_source = PC_SRC_ALU;
                // IR and PC load only on the cycle the instruction word actually arrives
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = ALU_SRC_B_IMM_SH2;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_REG;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALU_SRC_B_REG;
                o_ctrl.alu_op        = ALU_OP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PC_SRC_JUMP;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register, next-state logic and Mealy qualifiers.
// Define MULTICYCLE_ADDI_EN to add the ADDI execute/writeback states.
module multicycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_illegal;
    ctrl_word_t w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode is only trusted in DECODE and MEM_ADDR, where the IR is stable
    always_comb begin
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      w_next_state = S_ADDI_EX;
`endif
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    w_next_state = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    w_next_state = S_MEM_WRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEM_READ:  if (mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECUTE:   w_next_state = S_R_WB;
            S_R_WB:      w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX:   w_next_state = S_ADDI_WB;
            S_ADDI_WB:   w_next_state = S_FETCH;
`endif
            default:     w_next_state = S_FETCH;
        endcase
    end

    ctrl_out_decode u_ctrl_out_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign pc_en         = w_ctrl.pc_write | (w_ctrl.pc_write_cond & zero);
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = w_illegal;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors, expected words queued, monitor compares.
// Build with MULTICYCLE_ADDI_EN defined to exercise the ADDI path.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [21:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_en         (pc_en),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, written directly from the state/output table
    function automatic logic [21:0] exp_word(input logic [3:0] st, input logic mr,
                                             input logic z, input logic [5:0] op);
        logic pw, pwc, pe, iod, mrd, mwr, irw, rd, m2r, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, pe, iod, mrd, mwr, irw, rd, m2r, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            4'd2:  begin
                asb = 2'b11;
                ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                        op == 6'b000100 || op == 6'b000010
`ifdef MULTICYCLE_ADDI_EN
                        || op == 6'b001000
`endif
                        );
            end
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; iod = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mwr = 1; iod = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; pe = z; end
            4'd10: begin pw = 1; pe = 1; psrc = 2'b10; end
            4'd11: begin asa = 1; asb = 2'b10; end
            4'd12: begin rw = 1; end
            default: ;
        endcase
        if (st == 4'd1) pe = mr;
        return {st, pw, pwc, pe, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
    endfunction

    // One stimulus cycle: drive after the rising edge, queue what the monitor should see this cycle
    task automatic cyc(input logic rst, input logic [5:0] op, input logic mr, input logic z,
                       input logic [3:0] st, input string nm);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        it.exp    = rst ? exp_word(st, mr, z, op) : 22'd0;
        it.name   = nm;
        sb_q.push_back(it);
    endtask

    // Monitor: compares the DUT outputs against the queued expectation mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            logic [21:0] act;
            it  = sb_q.pop_front();
            act = {state, pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
            n_tests++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: actual=%06h expected=%06h (state act=%0d exp=%0d)",
                         it.name, act, it.exp, act[21:18], it.exp[21:18]);
            end
        end
    end

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] JP = 6'b000010;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] BD = 6'b111111;

    initial begin
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
        cyc(0, R, 0, 0, 4'd0, "reset_hold");
        cyc(1, R, 0, 0, 4'd0, "reset_release_idle");
        // R-type
        cyc(1, R, 1, 0, 4'd1, "r_fetch");
        cyc(1, R, 1, 0, 4'd2, "r_decode");
        cyc(1, R, 1, 0, 4'd7, "r_execute");
        cyc(1, R, 1, 0, 4'd8, "r_wb");
        // Fetch wait then LW with two MEM_READ wait cycles
        cyc(1, LW, 0, 0, 4'd1, "fetch_wait0");
        cyc(1, LW, 0, 0, 4'd1, "fetch_wait1");
        cyc(1, LW, 0, 0, 4'd1, "fetch_wait2");
        cyc(1, LW, 1, 0, 4'd1, "lw_fetch");
        cyc(1, LW, 0, 0, 4'd2, "lw_decode");
        cyc(1, LW, 1, 0, 4'd3, "lw_mem_addr");
        cyc(1, LW, 0, 0, 4'd4, "lw_mem_read_w0");
        cyc(1, LW, 0, 0, 4'd4, "lw_mem_read_w1");
        cyc(1, LW, 1, 0, 4'd4, "lw_mem_read_done");
        cyc(1, LW, 1, 0, 4'd5, "lw_mem_wb");
        // BEQ taken / not taken
        cyc(1, BQ, 1, 0, 4'd1, "beq1_fetch");
        cyc(1, BQ, 1, 0, 4'd2, "beq1_decode");
        cyc(1, BQ, 1, 1, 4'd9, "beq1_branch_taken");
        cyc(1, BQ, 1, 1, 4'd1, "beq2_fetch");
        cyc(1, BQ, 1, 1, 4'd2, "beq2_decode");
        cyc(1, BQ, 1, 0, 4'd9, "beq2_branch_not_taken");
        // Jump
        cyc(1, JP, 1, 0, 4'd1, "j_fetch");
        cyc(1, JP, 1, 0, 4'd2, "j_decode");
        cyc(1, JP, 1, 0, 4'd10, "j_jump");
        // Illegal opcodes
        cyc(1, BD, 1, 0, 4'd1, "bad_fetch");
        cyc(1, BD, 1, 0, 4'd2, "bad_decode_illegal");
        cyc(1, AI, 1, 0, 4'd1, "addi_fetch");
        cyc(1, AI, 1, 0, 4'd2, "addi_decode");
`ifdef MULTICYCLE_ADDI_EN
        cyc(1, AI, 1, 0, 4'd11, "addi_ex");
        cyc(1, AI, 1, 0, 4'd12, "addi_wb");
`endif
        // SW completing after one wait
        cyc(1, SW, 1, 0, 4'd1, "sw_fetch");
        cyc(1, SW, 1, 0, 4'd2, "sw_decode");
        cyc(1, SW, 0, 0, 4'd3, "sw_mem_addr");
        cyc(1, SW, 0, 0, 4'd6, "sw_mem_write_w0");
        cyc(1, SW, 1, 0, 4'd6, "sw_mem_write_done");
        // SW aborted by reset mid-MEM_WRITE
        cyc(1, SW, 1, 0, 4'd1, "sw2_fetch");
        cyc(1, SW, 1, 0, 4'd2, "sw2_decode");
        cyc(1, SW, 0, 0, 4'd3, "sw2_mem_addr");
        cyc(1, SW, 0, 0, 4'd6, "sw2_mem_write_wait");
        cyc(0, SW, 0, 0, 4'd0, "sw2_reset_abort");
        cyc(1, R, 0, 0, 4'd0, "post_reset_idle");
        cyc(1, R, 0, 0, 4'd1, "post_reset_fetch");
        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d pending expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
